// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding
// and stream framing constants.
package boot_pkg;

    localparam logic [2:0] ST_HDR_LO = 3'd0;
    localparam logic [2:0] ST_HDR_HI = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    typedef enum logic [2:0] {
        HDR_LO = ST_HDR_LO,
        HDR_HI = ST_HDR_HI,
        DATA   = ST_DATA,
        DONE   = ST_DONE,
        ERR    = ST_ERR
    } boot_state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Collects bytes into a little-endian 32-bit word; word/word_valid are
// combinational so the caller can register the word on the 4th byte's edge.
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      buf_q, buf_d;

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        word_valid = 1'b0;
        word       = {byte_data, buf_q};
        if (byte_valid) begin
            cnt_d = cnt_q + 1'b1;
            case (cnt_q)
                2'd0:    buf_d[7:0]   = byte_data;
                2'd1:    buf_d[15:8]  = byte_data;
                2'd2:    buf_d[23:16] = byte_data;
                default: word_valid   = 1'b1;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the
// core in reset until the last word has been written.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    boot_state_e       state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_reset_q, core_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic [15:0]       words_loaded_q, words_loaded_d;

    logic        accept;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] n_full;

    assign accept = rx_valid && rx_ready_q;
    assign n_full = {rx_data, n_q[7:0]};

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (accept && (state_q == DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            HDR_LO: if (accept) begin
                n_d     = {8'h00, rx_data};
                state_d = HDR_HI;
            end
            HDR_HI: if (accept) begin
                n_d = n_full;
                if (n_full == 16'd0)                 state_d = DONE;
                else if ({16'h0, n_full} > CAPACITY) state_d = ERR;
                else                                 state_d = DATA;
            end
            DATA: if (word_valid) begin
                imem_we_d    = 1'b1;
                imem_wdata_d = word;
                imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                word_cnt_d   = word_cnt_q + 16'd1;
                if ({1'b0, word_cnt_q} + 17'd1 == {1'b0, n_q}) state_d = DONE;
            end
            default: ;
        endcase

        // Ready follows the next state so no byte is handshaken once DONE/ERR is entered.
        rx_ready_d     = (state_d == HDR_LO) || (state_d == HDR_HI) || (state_d == DATA);
        core_reset_d   = (state_q != DONE);
        load_done_d    = (state_q == DONE);
        load_err_d     = (state_q == ERR);
        words_loaded_d = words_loaded_q;
        if (imem_we_q && (words_loaded_q != 16'hFFFF)) words_loaded_d = words_loaded_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= HDR_LO;
            n_q            <= '0;
            word_cnt_q     <= '0;
            rx_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            core_reset_q   <= 1'b1;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            word_cnt_q     <= word_cnt_d;
            rx_ready_q     <= rx_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_reset_q   <= core_reset_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_reset   = core_reset_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: byte streams in, write log and
// control outputs compared against hand-computed values.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              load_done;
    logic              load_err;
    logic [15:0]       words_loaded;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t wlog[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  last_we_cyc = -100;
    int  spacing_viol = 0;
    bit  rand_gaps = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_we) begin
            wlog.push_back('{addr: imem_addr, data: imem_wdata});
            if (cyc - last_we_cyc < 4) spacing_viol <= spacing_viol + 1;
            last_we_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_load_done", load_done, 0);
        check("rst_load_err", load_err, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_words_loaded", words_loaded, 0);
        reset = 1'b0;
        wlog.delete();
    endtask

    // Presents one byte and returns just after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        while (rand_gaps && ($urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!rx_ready) check("send_timeout_rx_ready", rx_ready, 1);
        else tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    initial begin
        int bad;
        int zero_writes;
        int stuck;
        int log_n;

        do_reset();

        // Two-word program, back to back.
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h00A00513);
        send_word(32'h00B00593);
        check("t1_we_at_E", imem_we, 1);
        check("t1_wdata_at_E", imem_wdata, 32'h00B00593);
        check("t1_addr_at_E", imem_addr, 1);
        check("t1_core_reset_at_E", core_reset, 1);
        check("t1_ready_at_E", rx_ready, 0);
        rx_valid = 1'b0;
        tick();
        check("t1_core_reset_E1", core_reset, 0);
        check("t1_load_done_E1", load_done, 1);
        check("t1_we_E1", imem_we, 0);
        check("t1_words_loaded", words_loaded, 2);
        check("t1_log_size", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("t1_w0_addr", wlog[0].addr, 0);
            check("t1_w0_data", wlog[0].data, 32'h00A00513);
            check("t1_w1_addr", wlog[1].addr, 1);
            check("t1_w1_data", wlog[1].data, 32'h00B00593);
        end

        // Empty image.
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        rx_valid = 1'b0;
        check("t2_core_reset_at_E", core_reset, 1);
        tick();
        check("t2_core_reset_E1", core_reset, 0);
        check("t2_load_done", load_done, 1);
        tick();
        check("t2_no_writes", wlog.size(), 0);
        check("t2_words_loaded", words_loaded, 0);

        // Oversized header N=257 with ADDR_W=8.
        do_reset();
        send_byte(8'h01); send_byte(8'h01);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick();
        stuck = 0;
        for (int i = 0; i < 100; i++) begin
            if (!core_reset || rx_ready || !load_err || load_done) stuck++;
            tick();
        end
        rx_valid = 1'b0;
        check("t3_err_hold_violations", stuck, 0);
        check("t3_load_err", load_err, 1);
        check("t3_no_writes", wlog.size(), 0);

        // Full memory, word i = i.
        do_reset();
        send_byte(8'h00); send_byte(8'h01);
        for (int i = 0; i < 256; i++) send_word(32'(i));
        rx_valid = 1'b0;
        tick();
        check("t4_log_size", wlog.size(), 256);
        bad = 0;
        zero_writes = 0;
        foreach (wlog[i]) begin
            if (wlog[i].addr != ADDR_W'(i) || wlog[i].data != 32'(i)) bad++;
            if (wlog[i].addr == '0) zero_writes++;
        end
        check("t4_order_bad", bad, 0);
        check("t4_addr0_writes", zero_writes, 1);
        if (wlog.size() > 0) check("t4_last_addr", wlog[wlog.size()-1].addr, 8'hFF);
        check("t4_load_done", load_done, 1);
        check("t4_core_reset", core_reset, 0);
        check("t4_words_loaded", words_loaded, 256);

        // Random valid gaps, N=3, then bytes offered in DONE are ignored.
        do_reset();
        rand_gaps = 1'b1;
        send_byte(8'h03); send_byte(8'h00);
        send_word(32'h00A00513);
        send_word(32'h00B00593);
        send_word(32'h12345678);
        rand_gaps = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (6) tick();
        rx_valid = 1'b0;
        check("t5_log_size", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("t5_w0", {24'h0, wlog[0].addr} ^ wlog[0].data, 32'h00A00513);
            check("t5_w1", {24'h0, wlog[1].addr} ^ wlog[1].data, 32'h00B00592);
            check("t5_w2", {24'h0, wlog[2].addr} ^ wlog[2].data, 32'h1234567A);
        end
        check("t5_words_loaded", words_loaded, 3);
        check("t5_load_done", load_done, 1);

        // Reset mid-load, then a fresh single-word image.
        do_reset();
        send_byte(8'h04); send_byte(8'h00);
        send_word(32'h11223344);
        send_byte(8'h55); send_byte(8'h66);
        rx_valid = 1'b0;
        tick();
        check("t6_pre_reset_words", words_loaded, 1);
        check("t6_pre_reset_core_reset", core_reset, 1);
        do_reset();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDEADBEEF);
        rx_valid = 1'b0;
        tick();
        log_n = wlog.size();
        check("t6_log_size", log_n, 1);
        if (log_n == 1) begin
            check("t6_addr", wlog[0].addr, 0);
            check("t6_data", wlog[0].data, 32'hDEADBEEF);
        end
        check("t6_words_loaded", words_loaded, 1);
        check("t6_core_reset", core_reset, 0);

        check("we_spacing_violations", spacing_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
